// File: rtl/tmr_key_ctrl.sv
// Kitchen-timer key front end (2-FF sync, run-length debounce, press events) and control FSM.
// Optional macro KEY_REPEAT_EN adds auto-repeat of the increment key while held in IDLE.
module tmr_key_ctrl #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int BLINK_MS        = 250,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic        rst,
  input  logic        clk1k,
  input  logic [2:0]  key_n,
  input  logic        zero,
  output logic        run,
  output logic        load,
  output logic [15:0] preset,
  output logic [1:0]  dsel,
  output logic        alarm
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [DW-1:0] DB_LIMIT   = DW'(DEBOUNCE_MS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  if (DEBOUNCE_MS < 1 || BLINK_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_param_check
    $error("tmr_key_ctrl: timing parameters must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] bcd_digit_inc(input logic [15:0] value, input logic [1:0] sel);
    logic [15:0] result;
    logic [3:0]  digit;
    result = value;
    digit  = value[{sel, 2'b00} +: 4];
    if (digit >= 4'd9) begin
      digit = 4'd0;
    end else begin
      digit = digit + 4'd1;
    end
    result[{sel, 2'b00} +: 4] = digit;
    return result;
  endfunction

  logic [2:0]    sync1_r, sync2_r, prev_r, db_r, armed_r, press_r;
  logic [DW-1:0] cnt_r     [3];
  logic [DW-1:0] run_len_s [3];
  logic [2:0]    stable_s;

  // run length of identical synchronized samples, saturating at DEBOUNCE_MS
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (sync2_r[i] != prev_r[i]) begin
        run_len_s[i] = DW'(1);
      end else if (cnt_r[i] == DB_LIMIT) begin
        run_len_s[i] = DB_LIMIT;
      end else begin
        run_len_s[i] = cnt_r[i] + DW'(1);
      end
      stable_s[i] = (run_len_s[i] == DB_LIMIT);
    end
  end

  // synchronizers, debounced levels and press events; a key is armed only after a debounced release
  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      prev_r  <= 3'b111;
      db_r    <= 3'b111;
      armed_r <= 3'b000;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i]   <= run_len_s[i];
        press_r[i] <= stable_s[i] & db_r[i] & ~sync2_r[i] & armed_r[i];
        if (stable_s[i]) begin
          db_r[i] <= sync2_r[i];
          if (sync2_r[i]) armed_r[i] <= 1'b1;
        end
      end
    end
  end

  logic ev0_s, ev1_s, ev2_s, any_ev_s, inc_s;
  assign ev0_s    = press_r[0];
  assign ev1_s    = press_r[1] & ~press_r[0];
  assign ev2_s    = press_r[2] & ~press_r[1] & ~press_r[0];
  assign any_ev_s = |press_r;

  state_t        state_r, state_s;
  logic [15:0]   preset_r, preset_s;
  logic [1:0]    dsel_r, dsel_s;
  logic [BW-1:0] blink_r, blink_s;
  logic          run_r, load_r, load_s, alarm_r, alarm_s;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST = RW'(REPEAT_DELAY_MS - 1);
  localparam logic [RW-1:0] RPT_RATE_LAST  = RW'(REPEAT_RATE_MS - 1);

  logic          rpt_active_r, rpt_first_r, rpt_fire_s, rpt_hold_s;
  logic [RW-1:0] rpt_cnt_r;

  assign rpt_hold_s = (state_r == S_IDLE) & ~db_r[2];

  // repeat fires when the hold timer reaches the initial delay, then the repeat interval
  always_comb begin
    rpt_fire_s = 1'b0;
    if (rpt_active_r && rpt_hold_s) begin
      if (rpt_first_r) begin
        rpt_fire_s = (rpt_cnt_r == RPT_DELAY_LAST);
      end else begin
        rpt_fire_s = (rpt_cnt_r == RPT_RATE_LAST);
      end
    end else begin
      rpt_fire_s = 1'b0;
    end
  end

  // hold timer, started by an accepted increment press and dropped on release or state exit
  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      rpt_active_r <= 1'b0;
      rpt_first_r  <= 1'b1;
      rpt_cnt_r    <= '0;
    end else if (!rpt_hold_s) begin
      rpt_active_r <= 1'b0;
      rpt_first_r  <= 1'b1;
      rpt_cnt_r    <= '0;
    end else if (ev2_s) begin
      rpt_active_r <= 1'b1;
      rpt_first_r  <= 1'b1;
      rpt_cnt_r    <= '0;
    end else if (rpt_active_r) begin
      if (rpt_fire_s) begin
        rpt_first_r <= 1'b0;
        rpt_cnt_r   <= '0;
      end else begin
        rpt_cnt_r <= rpt_cnt_r + RW'(1);
      end
    end
  end

  assign inc_s = ev2_s | (rpt_fire_s & ~press_r[0] & ~press_r[1]);
`else
  assign inc_s = ev2_s;
`endif

  // next state, editing and alarm blink
  always_comb begin
    state_s  = state_r;
    preset_s = preset_r;
    dsel_s   = dsel_r;
    load_s   = 1'b0;
    alarm_s  = 1'b0;
    blink_s  = '0;
    case (state_r)
      S_IDLE: begin
        if (ev0_s) begin
          if (preset_r != 16'h0000) begin
            state_s = S_RUN;
            load_s  = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end else if (ev1_s) begin
          dsel_s = dsel_r + 2'd1;
        end else if (inc_s) begin
          preset_s = bcd_digit_inc(preset_r, dsel_r);
        end else begin
          preset_s = preset_r;
        end
      end
      S_RUN: begin
        if (zero) begin
          state_s = S_DONE;
          alarm_s = 1'b1;
        end else if (ev0_s) begin
          state_s = S_PAUSE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ev0_s) begin
          state_s = S_RUN;
        end else if (ev1_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (any_ev_s) begin
          state_s = S_IDLE;
        end else if (blink_r == BLINK_LAST) begin
          alarm_s = ~alarm_r;
        end else begin
          alarm_s = alarm_r;
          blink_s = blink_r + BW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // state and registered outputs; load and run rise on the same edge
  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      preset_r <= 16'h9999;
      dsel_r   <= 2'd0;
      blink_r  <= '0;
      run_r    <= 1'b0;
      load_r   <= 1'b0;
      alarm_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      preset_r <= preset_s;
      dsel_r   <= dsel_s;
      blink_r  <= blink_s;
      run_r    <= (state_s == S_RUN);
      load_r   <= load_s;
      alarm_r  <= alarm_s;
    end
  end

  assign run    = run_r;
  assign load   = load_r;
  assign preset = preset_r;
  assign dsel   = dsel_r;
  assign alarm  = alarm_r;

endmodule

// File: tb/tb_tmr_key_ctrl.sv
// Self-checking bench for tmr_key_ctrl: scenario tasks plus randomized key editing against a behavioural model.
`timescale 1ns/1ps
module tb_tmr_key_ctrl;

  localparam int DEB   = 20;
  localparam int BLINK = 250;
  localparam int RDLY  = 500;
  localparam int RRATE = 100;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        rst, clk1k, zero;
  logic [2:0]  key_n;
  logic        run, load, alarm;
  logic [15:0] preset;
  logic [1:0]  dsel;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int load_cnt = 0, load_norun = 0, load_long = 0, exp_loads = 0;
  logic load_prev = 1'b0;

  // model: 0 idle, 1 run, 2 pause, 3 done
  int         m_state;
  logic [3:0] m_dig [4];
  logic [1:0] m_dsel;

  tmr_key_ctrl #(.DEBOUNCE_MS(DEB), .BLINK_MS(BLINK), .REPEAT_DELAY_MS(RDLY), .REPEAT_RATE_MS(RRATE)) dut (
    .rst(rst), .clk1k(clk1k), .key_n(key_n), .zero(zero),
    .run(run), .load(load), .preset(preset), .dsel(dsel), .alarm(alarm)
  );

  initial clk1k = 1'b0;
  always #5 clk1k = ~clk1k;
  always @(posedge clk1k) cyc++;

  // load pulse monitor, sampled mid-cycle
  always @(negedge clk1k) begin
    if (load) load_cnt++;
    if (load && !run) load_norun++;
    if (load && load_prev) load_long++;
    load_prev = load;
  end

  function automatic logic [15:0] model_preset();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_dsel  = 2'd0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd9;
  endtask

  // the winning key of a simultaneous press applied to the model
  task automatic model_event(input logic [2:0] mask);
    if (mask[0]) begin
      if (m_state == 0) begin
        if (model_preset() != 16'h0000) begin
          m_state = 1;
          exp_loads++;
        end
      end else if (m_state == 1) m_state = 2;
      else if (m_state == 2) m_state = 1;
      else m_state = 0;
    end else if (mask[1]) begin
      if (m_state == 0) m_dsel = m_dsel + 2'd1;
      else if (m_state != 1) m_state = 0;
    end else if (mask[2]) begin
      if (m_state == 0) m_dig[m_dsel] = (m_dig[m_dsel] == 4'd9) ? 4'd0 : m_dig[m_dsel] + 4'd1;
      else if (m_state == 3) m_state = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk1k); #2;
    rst = 1'b0; key_n = 3'b111; zero = 1'b0;
    repeat (3) @(posedge clk1k);
    #1 rst = 1'b1;
    repeat (30) @(posedge clk1k);
    #1;
    model_reset();
  endtask

  // optional 3-cycle bounce pieces (odd count ends low), then a steady hold, release, settle
  task automatic press_keys(input logic [2:0] mask, input int bounce, input int hold);
    for (int i = 0; i < bounce; i++) begin
      key_n = (i % 2 == 0) ? ~mask : 3'b111;
      repeat (3) @(posedge clk1k);
      #1;
    end
    key_n = ~mask;
    repeat (hold) @(posedge clk1k);
    #1 key_n = 3'b111;
    repeat (30) @(posedge clk1k);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 3'b111; zero = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({run, load, alarm, dsel, preset} !== {1'b0, 1'b0, 1'b0, 2'd0, 16'h9999}) begin
      errors++;
      $display("FAIL reset_state: got run=%b load=%b alarm=%b dsel=%0d preset=%h, want 0 0 0 0 9999",
               run, load, alarm, dsel, preset);
    end
    key_n = 3'b110;
    repeat (3) @(posedge clk1k);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk1k);
    #1;
    checks++;
    if (load_cnt !== 0 || run !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset: got loads=%0d run=%b, want 0 0", load_cnt, run);
    end
    key_n = 3'b111;
    repeat (30) @(posedge clk1k);
    #1;
    model_reset();
  endtask

  task automatic test_start();
    press_keys(3'b001, 0, 25);
    model_event(3'b001);
    checks++;
    if (load_cnt !== exp_loads || load_norun !== 0 || load_long !== 0) begin
      errors++;
      $display("FAIL start_load: got loads=%0d norun=%0d long=%0d, want %0d 0 0", load_cnt, load_norun, load_long, exp_loads);
    end
    checks++;
    if ({run, alarm, preset} !== {1'b1, 1'b0, 16'h9999}) begin
      errors++;
      $display("FAIL start_run: got run=%b alarm=%b preset=%h, want 1 0 9999", run, alarm, preset);
    end
  endtask

  task automatic test_pause_abort();
    logic [2:0] seq [6];
    seq = '{3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
    for (int i = 0; i < 6; i++) begin
      press_keys(seq[i], 1, 30);
      model_event(seq[i]);
      checks++;
      if ({run, alarm, dsel, preset} !== {(m_state == 1), 1'b0, m_dsel, model_preset()} || load_cnt !== exp_loads) begin
        errors++;
        $display("FAIL pause_step%0d: got run=%b alarm=%b dsel=%0d preset=%h loads=%0d, want run=%b dsel=%0d preset=%h loads=%0d",
                 i, run, alarm, dsel, preset, load_cnt, (m_state == 1), m_dsel, model_preset(), exp_loads);
      end
    end
  endtask

  task automatic test_reset_abort();
    press_keys(3'b001, 0, 30);
    model_event(3'b001);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({run, load, alarm} !== 3'b000) begin
      errors++;
      $display("FAIL abort_run: got run=%b load=%b alarm=%b, want 000", run, load, alarm);
    end
    do_reset();
    press_keys(3'b001, 0, 30);
    model_event(3'b001);
    zero = 1'b1;
    repeat (3) @(posedge clk1k);
    #1;
    checks++;
    if ({run, alarm} !== 2'b01) begin
      errors++;
      $display("FAIL done_entry: got run=%b alarm=%b, want 0 1", run, alarm);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({run, load, alarm} !== 3'b000) begin
      errors++;
      $display("FAIL abort_done: got run=%b load=%b alarm=%b, want 000", run, load, alarm);
    end
    do_reset();
    checks++;
    if (load_cnt !== exp_loads || load_long !== 0) begin
      errors++;
      $display("FAIL abort_load: got loads=%0d long=%0d, want %0d 0", load_cnt, load_long, exp_loads);
    end
  endtask

  task automatic test_dsel_inc();
    do_reset();
    for (int i = 0; i < 5; i++) press_keys(3'b010, 0, 30);
    checks++;
    if (dsel !== 2'd1) begin
      errors++;
      $display("FAIL dsel_wrap: got %0d, want 1", dsel);
    end
    for (int i = 0; i < 2; i++) press_keys(3'b100, 0, 30);
    checks++;
    if (preset !== 16'h9919) begin
      errors++;
      $display("FAIL digit1_inc: got %h, want 9919", preset);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    press_keys(3'b100, 5, 30);
    checks++;
    if (preset !== 16'h9990) begin
      errors++;
      $display("FAIL bounce_once: got %h, want 9990", preset);
    end
  endtask

  task automatic test_zero_preset();
    logic [2:0] seq [7];
    do_reset();
    seq = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    for (int i = 0; i < 7; i++) press_keys(seq[i], 0, 30);
    checks++;
    if ({dsel, preset} !== {2'd3, 16'h0000}) begin
      errors++;
      $display("FAIL all_zero_edit: got dsel=%0d preset=%h, want 3 0000", dsel, preset);
    end
    press_keys(3'b001, 0, 30);
    checks++;
    if (run !== 1'b0 || load_cnt !== exp_loads) begin
      errors++;
      $display("FAIL zero_start: got run=%b loads=%0d, want 0 %0d", run, load_cnt, exp_loads);
    end
  endtask

  // zero is raised so that it and the key0 press event reach the FSM on the same edge
  task automatic test_done_alarm();
    int e;
    int pts [4];
    logic expv [4];
    pts  = '{249, 250, 499, 500};
    expv = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    press_keys(3'b001, 0, 30);
    model_event(3'b001);
    key_n = 3'b110;
    repeat (DEB + 2) @(posedge clk1k);
    #1 zero = 1'b1;
    @(posedge clk1k);
    #1 e = cyc;
    zero = 1'b0;
    key_n = 3'b111;
    @(negedge clk1k);
    checks++;
    if ({run, alarm} !== 2'b01) begin
      errors++;
      $display("FAIL done_priority: got run=%b alarm=%b, want 0 1", run, alarm);
    end
    for (int i = 0; i < 4; i++) begin
      while (cyc < e + pts[i]) @(negedge clk1k);
      checks++;
      if (alarm !== expv[i]) begin
        errors++;
        $display("FAIL blink_at_%0d: got %b, want %b", pts[i], alarm, expv[i]);
      end
    end
    press_keys(3'b010, 0, 30);
    checks++;
    if ({run, alarm, dsel} !== {1'b0, 1'b0, 2'd0} || load_cnt !== exp_loads) begin
      errors++;
      $display("FAIL done_exit: got run=%b alarm=%b dsel=%0d loads=%0d, want 0 0 0 %0d", run, alarm, dsel, load_cnt, exp_loads);
    end
  endtask

  task automatic test_random();
    logic [2:0] mask;
    int bounce;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       mask = 3'b010;
        1:       mask = 3'b100;
        default: mask = 3'b110;
      endcase
      bounce = 2 * $urandom_range(0, 2) + 1;
      press_keys(mask, bounce, 25 + $urandom_range(0, 10));
      model_event(mask);
      checks++;
      if ({run, alarm, dsel, preset} !== {1'b0, 1'b0, m_dsel, model_preset()}) begin
        errors++;
        $display("FAIL random_%0d mask=%b: got dsel=%0d preset=%h, want dsel=%0d preset=%h",
                 n, mask, dsel, preset, m_dsel, model_preset());
      end
    end
  endtask

  task automatic test_repeat();
    int held, incs;
    logic [3:0] want;
    do_reset();
    held = 1050;
    key_n = 3'b011;
    repeat (held) @(posedge clk1k);
    #1 key_n = 3'b111;
    repeat (40) @(posedge clk1k);
    #1;
    incs = 1;
    if (REP_EN && held >= RDLY) incs = 2 + (held - RDLY) / RRATE;
    want = 4'((9 + incs) % 10);
    checks++;
    if (preset !== {12'h999, want}) begin
      errors++;
      $display("FAIL hold_repeat: got %h, want 999%h (%0d increments)", preset, want, incs);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_pause_abort();
    test_reset_abort();
    test_dsel_inc();
    test_bounce();
    test_zero_preset();
    test_done_alarm();
    test_random();
    test_repeat();
    checks++;
    if (load_norun !== 0 || load_long !== 0) begin
      errors++;
      $display("FAIL load_shape: got norun=%0d long=%0d, want 0 0", load_norun, load_long);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
